round_judge: RTL and testbench

- Per-round controller that sits directly upstream of score_counter and drives its is_equal input.
- Picks a pseudo-random target value with an LFSR and holds it while the player enters a guess on switches.
- Judges each submit against the target and enforces a per-round timeout.
- Emits exactly one result pulse per round (hit or miss) and sequences a fixed number of rounds before game over.

---
 rtl/game_pkg.sv | 17 +
 rtl/round_judge_if.sv | 24 ++
 rtl/lfsr_gen.sv | 23 ++
 rtl/round_judge.sv | 109 ++++++++++
 tb/tb_round_judge.sv | 201 ++++++++++++++++++++
 5 files changed

// File: rtl/game_pkg.sv
// Shared definitions for the guessing-game stages: state encoding, LFSR taps, default widths.
package game_pkg;

    localparam int DEF_WIDTH = 8;

    // Right-shifting Galois mask for x^8+x^6+x^5+x^4+1.
    localparam logic [7:0] LFSR_TAPS = 8'hB8;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_LOAD   = 3'd1,
        ST_PLAY   = 3'd2,
        ST_RESULT = 3'd3,
        ST_DONE   = 3'd4
    } state_t;

endpackage

// File: rtl/round_judge_if.sv
// Player-side controls and judged results of one round_judge instance.
interface round_judge_if #(
    parameter int WIDTH = 8
);
    logic             start;
    logic             submit;
    logic [WIDTH-1:0] guess;
    logic [WIDTH-1:0] target;
    logic             is_equal;
    logic             is_miss;
    logic             round_active;
    logic [3:0]       rounds_left;
    logic             game_over;

    modport master (
        output start, submit, guess,
        input  target, is_equal, is_miss, round_active, rounds_left, game_over
    );

    modport slave (
        input  start, submit, guess,
        output target, is_equal, is_miss, round_active, rounds_left, game_over
    );
endinterface

// File: rtl/lfsr_gen.sv
// Free-running Galois LFSR; a non-zero seed keeps it out of the all-zero lockup state.
module lfsr_gen
    import game_pkg::*;
#(
    parameter int               WIDTH = DEF_WIDTH,
    parameter logic [WIDTH-1:0] SEED  = 8'hA5,
    parameter logic [WIDTH-1:0] TAPS  = LFSR_TAPS
) (
    input  logic             clk,
    input  logic             rst,
    output logic [WIDTH-1:0] value
);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst)
            value <= SEED;
        else if (value[0])
            value <= (value >> 1) ^ TAPS;
        else
            value <= value >> 1;
    end

endmodule

// File: rtl/round_judge.sv
// Round controller: draws a target, judges submits or timeouts, and issues one hit/miss pulse per round.
module round_judge
    import game_pkg::*;
#(
    parameter int               WIDTH          = DEF_WIDTH,
    parameter logic [15:0]      TIMEOUT_CYCLES = 16'd50000,
    parameter int               NUM_ROUNDS     = 15,
    parameter logic [WIDTH-1:0] LFSR_SEED      = 8'hA5
) (
    input logic          clk,
    input logic          rst,
    round_judge_if.slave bus
);

    localparam int               TW          = $clog2(TIMEOUT_CYCLES);
    localparam logic [TW-1:0]    TIMER_INIT  = TW'(TIMEOUT_CYCLES - 16'd1);
    localparam logic [3:0]       ROUNDS_INIT = 4'(NUM_ROUNDS);

    state_t           state, state_d;
    logic [WIDTH-1:0] lfsr_value;
    logic [WIDTH-1:0] target, target_d;
    logic [TW-1:0]    timer, timer_d;
    logic [3:0]       rounds_left, rounds_d;
    logic             is_equal, is_equal_d;
    logic             is_miss, is_miss_d;
    logic             round_active, game_over;

    lfsr_gen #(
        .WIDTH (WIDTH),
        .SEED  (LFSR_SEED),
        .TAPS  (WIDTH'(LFSR_TAPS))
    ) u_lfsr (
        .clk   (clk),
        .rst   (rst),
        .value (lfsr_value)
    );

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state        <= ST_IDLE;
            target       <= '0;
            timer        <= '0;
            rounds_left  <= '0;
            is_equal     <= 1'b0;
            is_miss      <= 1'b0;
            round_active <= 1'b0;
            game_over    <= 1'b0;
        end else begin
            state        <= state_d;
            target       <= target_d;
            timer        <= timer_d;
            rounds_left  <= rounds_d;
            is_equal     <= is_equal_d;
            is_miss      <= is_miss_d;
            round_active <= (state_d == ST_PLAY);
            game_over    <= (state_d == ST_DONE);
        end
    end

    always_comb begin
        state_d    = state;
        target_d   = target;
        timer_d    = timer;
        rounds_d   = rounds_left;
        is_equal_d = 1'b0;
        is_miss_d  = 1'b0;
        case (state)
            ST_IDLE, ST_DONE: begin
                if (bus.start) begin
                    state_d  = ST_LOAD;
                    rounds_d = ROUNDS_INIT;
                end
            end
            ST_LOAD: begin
                target_d = lfsr_value;
                timer_d  = TIMER_INIT;
                state_d  = ST_PLAY;
            end
            ST_PLAY: begin
                // A submit on the last timer cycle wins over the timeout.
                if (bus.submit) begin
                    state_d = ST_RESULT;
                    if (bus.guess == target)
                        is_equal_d = 1'b1;
                    else
                        is_miss_d = 1'b1;
                end else if (timer == '0) begin
                    state_d   = ST_RESULT;
                    is_miss_d = 1'b1;
                end else begin
                    timer_d = timer - TW'(1);
                end
            end
            ST_RESULT: begin
                rounds_d = rounds_left - 4'd1;
                state_d  = (rounds_left == 4'd1) ? ST_DONE : ST_LOAD;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    assign bus.target       = target;
    assign bus.is_equal     = is_equal;
    assign bus.is_miss      = is_miss;
    assign bus.round_active = round_active;
    assign bus.rounds_left  = rounds_left;
    assign bus.game_over    = game_over;

endmodule

// File: tb/tb_round_judge.sv
// Bench for round_judge: directed rounds, pulses checked by a queue-driven monitor.
module tb_round_judge;

    logic clk = 1'b0;
    logic rst = 1'b0;
    always #5 clk = ~clk;

    round_judge_if #(.WIDTH(8)) bus();

    round_judge #(
        .WIDTH          (8),
        .TIMEOUT_CYCLES (16'd16),
        .NUM_ROUNDS     (3),
        .LFSR_SEED      (8'hA5)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    typedef struct {
        bit hit;
        int at;
    } exp_t;

    exp_t q[$];
    int   total = 0;
    int   bad   = 0;
    int   cyc   = 0;

    // Reference LFSR: x^8+x^6+x^5+x^4+1, shifting right, seed A5.
    logic [7:0] m;
    always @(posedge clk or negedge rst) begin
        if (!rst)   m <= 8'hA5;
        else if (m[0]) m <= {1'b0, m[7:1]} ^ 8'b1011_1000;
        else        m <= {1'b0, m[7:1]};
    end

    always @(posedge clk) cyc++;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h, expected %0h (cyc %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic tick(input int n = 1);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    // Monitor: every pulse cycle must match the next queued expectation.
    always @(negedge clk) begin
        if (rst && (bus.is_equal || bus.is_miss)) begin
            chk("pulse_exclusive", {31'd0, bus.is_equal & bus.is_miss}, 32'd0);
            if (q.size() == 0) begin
                total++;
                bad++;
                $display("FAIL unexpected_pulse: eq=%0b miss=%0b at cyc %0d", bus.is_equal, bus.is_miss, cyc);
            end else begin
                exp_t e;
                e = q.pop_front();
                chk("pulse_kind", {31'd0, bus.is_equal}, {31'd0, e.hit});
                chk("pulse_cyc", cyc, e.at);
            end
        end
    end

    logic [7:0] exp_tgt;
    int         play_cyc;

    // Called just after the edge that entered LOAD; ends just after PLAY entry.
    task automatic enter_play(input string tag);
        exp_tgt = m;
        tick();
        play_cyc = cyc;
        chk({tag, "_active"}, {31'd0, bus.round_active}, 32'd1);
        chk({tag, "_target"}, {24'd0, bus.target}, {24'd0, exp_tgt});
    endtask

    initial begin
        bus.start  = 1'b0;
        bus.submit = 1'b0;
        bus.guess  = 8'h00;
        #3;
        chk("rst_target", {24'd0, bus.target}, 32'd0);
        chk("rst_active", {31'd0, bus.round_active}, 32'd0);
        chk("rst_rounds", {28'd0, bus.rounds_left}, 32'd0);
        chk("rst_over", {31'd0, bus.game_over}, 32'd0);
        chk("rst_pulse", {30'd0, bus.is_equal, bus.is_miss}, 32'd0);
        tick(2);
        rst = 1'b1;
        tick(3);

        // Submit in IDLE must do nothing.
        bus.submit = 1'b1;
        tick();
        bus.submit = 1'b0;
        chk("idle_active", {31'd0, bus.round_active}, 32'd0);

        // Start -> LOAD -> PLAY.
        bus.start = 1'b1;
        tick();
        bus.start = 1'b0;
        chk("load_active", {31'd0, bus.round_active}, 32'd0);
        chk("load_rounds", {28'd0, bus.rounds_left}, 32'd3);
        enter_play("r1");

        // Round 1: correct guess.
        bus.guess  = exp_tgt;
        bus.submit = 1'b1;
        q.push_back('{hit: 1'b1, at: cyc + 1});
        tick();
        bus.submit = 1'b0;
        chk("r1_active_drop", {31'd0, bus.round_active}, 32'd0);
        tick();
        chk("r1_rounds", {28'd0, bus.rounds_left}, 32'd2);
        enter_play("r2");

        // Round 2: wrong guess.
        bus.guess  = exp_tgt ^ 8'h01;
        bus.submit = 1'b1;
        q.push_back('{hit: 1'b0, at: cyc + 1});
        tick();
        bus.submit = 1'b0;
        tick();
        chk("r2_rounds", {28'd0, bus.rounds_left}, 32'd1);
        enter_play("r3");

        // Round 3: start is ignored mid-round, then the round times out.
        q.push_back('{hit: 1'b0, at: play_cyc + 16});
        bus.start = 1'b1;
        tick();
        bus.start = 1'b0;
        chk("r3_start_ignored", {31'd0, bus.round_active}, 32'd1);
        chk("r3_rounds", {28'd0, bus.rounds_left}, 32'd1);
        for (int i = 0; i < 40 && cyc < play_cyc + 17; i++) tick();
        chk("done_over", {31'd0, bus.game_over}, 32'd1);
        chk("done_active", {31'd0, bus.round_active}, 32'd0);
        chk("done_rounds", {28'd0, bus.rounds_left}, 32'd0);
        chk("done_target_held", {24'd0, bus.target}, {24'd0, exp_tgt});

        // Submit in DONE must not pulse.
        bus.submit = 1'b1;
        tick();
        bus.submit = 1'b0;
        tick();
        chk("done_still_over", {31'd0, bus.game_over}, 32'd1);

        // Restart from DONE.
        bus.start = 1'b1;
        tick();
        bus.start = 1'b0;
        chk("restart_over", {31'd0, bus.game_over}, 32'd0);
        chk("restart_rounds", {28'd0, bus.rounds_left}, 32'd3);
        enter_play("g2r1");

        // Correct submit on the timer==0 cycle beats the timeout.
        tick(15);
        bus.guess  = exp_tgt;
        bus.submit = 1'b1;
        q.push_back('{hit: 1'b1, at: play_cyc + 16});
        tick();
        bus.submit = 1'b0;
        tick();
        chk("g2r1_rounds", {28'd0, bus.rounds_left}, 32'd2);
        enter_play("g2r2");

        // Asynchronous reset while a hit pulse is pending.
        tick(3);
        bus.guess  = exp_tgt;
        bus.submit = 1'b1;
        tick();
        bus.submit = 1'b0;
        chk("pending_hit", {31'd0, bus.is_equal}, 32'd1);
        #2;
        rst = 1'b0;
        #1;
        chk("arst_pulse", {30'd0, bus.is_equal, bus.is_miss}, 32'd0);
        chk("arst_target", {24'd0, bus.target}, 32'd0);
        chk("arst_active", {31'd0, bus.round_active}, 32'd0);
        chk("arst_rounds", {28'd0, bus.rounds_left}, 32'd0);
        chk("arst_over", {31'd0, bus.game_over}, 32'd0);
        tick(2);

        chk("queue_drained", q.size(), 32'd0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog: no finish by cyc %0d", cyc);
        $fatal(1, "watchdog");
    end

endmodule
